spi_flash_reader: RTL
=====================

// Module: spi_flash_reader
// PURPOSE
//  SPI master feeding the on-board flash SPI port (spi_clk/spi_cs/spi_mosi out, spi_miso in).
//  Accepts a byte-address read request and issues the standard READ command (0x03) plus a 24-bit address.
//  Shifts in DATA_BYTES bytes and returns them as one little-endian word on a valid/ready response channel.
//  Sits between the core's boot/MMIO flash window and the flash pin-level interface.
// PARAMETERS
//  CLK_DIV     2  system clocks per SPI half-period (>=1); one SPI bit = 2*CLK_DIV cycles
//  DATA_BYTES  8  bytes read per request (1..8); resp_data width = 8*DATA_BYTES
// PORTS
//  clock       in   1            system clock
//  reset       in   1            synchronous, active-high
//  req_valid   in   1            read request valid
//  req_ready   out  1            request accepted when req_valid&req_ready
//  req_addr    in   24           flash byte address, no alignment required
//  resp_valid  out  1            read data valid
//  resp_ready  in   1            consumer takes data when resp_valid&resp_ready
//  resp_data   out  8*DATA_BYTES byte at req_addr in [7:0], req_addr+1 in [15:8], ...
//  spi_clk     out  1            SPI clock, mode 0 (CPOL=0, CPHA=0)
//  spi_cs      out  1            chip select, active-low
//  spi_mosi    out  1            master out, MSB first
//  spi_miso    in   1            master in, MSB first within each byte
// BEHAVIOUR
//  Reset values: req_ready=0 in reset cycle then 1, resp_valid=0, resp_data=0, spi_clk=0, spi_cs=1, spi_mosi=0.
//  FSM: IDLE -> SHIFT -> GAP -> RESP -> IDLE.
//   IDLE: req_ready=1. On accept (cycle 0), latch {8'h03, req_addr} into a 32-bit tx shifter, clear rx.
//   SHIFT: from cycle 1 spi_cs=0. Total 32+8*DATA_BYTES bits, each bit = CLK_DIV low + CLK_DIV high cycles.
//    spi_mosi updates only while spi_clk is low, at the start of each bit; after the 32 tx bits spi_mosi=0.
//    spi_miso sampled on the system edge where spi_clk goes 0->1; samples only during the data phase.
//   GAP: after the last high phase, spi_clk=0 and spi_cs=1 on the same edge. resp_valid rises there too.
//    resp_valid for CLK_DIV=2, DATA_BYTES=8 first appears at cycle 1+96*4=385.
//    spi_cs stays high >= 2*CLK_DIV cycles; the gap counter runs concurrently with RESP.
//   RESP: resp_valid held, resp_data stable until resp_ready. Return to IDLE only when the response is taken and the gap has expired.
//  req_ready=0 in every state except IDLE; no request is queued.
//  Byte assembly: k-th received byte (k=0 first) lands in resp_data[8k+7:8k].
//  Address wrap: the flash handles addresses past 0xFFFFFF; the block sends the 24 bits unchanged.
//  spi_clk is a registered output, never gated from clock; no combinational path from spi_miso to any output.
//  Reset mid-transaction: next cycle spi_cs=1, spi_clk=0, partial data discarded, resp_valid=0, FSM=IDLE.
//  req_valid asserted during reset is ignored.
// STRUCTURE
//  Shared package spi_flash_pkg:
//   - localparam SPI_CMD_READ = 8'h03
//   - state enum {IDLE, SHIFT, GAP, RESP}
//  Sub-module spi_bit_timer (CLK_DIV): half-period counter producing the rise/fall strobes and spi_clk.
//  Top level holds the FSM, tx/rx shifters, bit counter and gap counter.
// TESTING (CLK_DIV=2, DATA_BYTES=8, behavioural flash model on the SPI pins)
//  1. Flash[0x10..0x17]=01..08, read 0x000010:
//     - MOSI bytes 03 00 00 10
//     - resp_valid at cycle 385, resp_data=0x0807060504030201
//  2. resp_ready held low 50 cycles:
//     - resp_valid and resp_data stable throughout, req_ready=0
//     - one cycle after handshake req_ready=1
//  3. Back-to-back requests, resp_ready=1:
//     - spi_cs high >= 4 cycles between transactions
//     - spi_clk=0 whenever spi_cs=1
//  4. Reset asserted at cycle 100 of a read:
//     - next cycle spi_cs=1, spi_clk=0, resp_valid=0
//     - a new read of 0x000010 returns 0x0807060504030201
//  5. Unaligned read 0xFFFFFD, model wraps to 0x000000:
//     - MOSI addr bytes FF FF FD
//     - bytes assembled in received order
//  6. CLK_DIV=1, DATA_BYTES=4:
//     - spi_clk period 2 cycles
//     - resp_valid at cycle 1+64*2=129, 32-bit resp_data correct

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash read path: command opcode, frame sizes and FSM states.
package spi_flash_pkg;

  localparam logic [7:0] SPI_CMD_READ = 8'h03;
  localparam int         CMD_BITS     = 32;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    RESP
  } state_t;

endpackage

// File: rtl/spi_bit_timer.sv
// SPI clock generator: counts half-periods while enabled and flags the edges on which
// spi_clk is about to rise or fall. Parked low with the counter cleared when disabled.
module spi_bit_timer #(
  parameter int CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic spi_clk,
  output logic rise,
  output logic fall
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;
  logic             clk_reg;
  logic             tick;

  assign tick    = en && (cnt_reg == CNT_W'(CLK_DIV - 1));
  assign rise    = tick && !clk_reg;
  assign fall    = tick && clk_reg;
  assign spi_clk = clk_reg;

  always_ff @(posedge clock) begin
    if (reset || !en) begin
      cnt_reg <= '0;
      clk_reg <= 1'b0;
    end else if (tick) begin
      cnt_reg <= '0;
      clk_reg <= ~clk_reg;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI mode-0 master issuing READ (0x03) + 24-bit address, then returning DATA_BYTES
// received bytes as one little-endian word on a valid/ready response channel.
module spi_flash_reader
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int DATA_BYTES = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [23:0]             req_addr,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [8*DATA_BYTES-1:0] resp_data,
  output logic                    spi_clk,
  output logic                    spi_cs,
  output logic                    spi_mosi,
  input  logic                    spi_miso
);

  localparam int DATA_W     = 8 * DATA_BYTES;
  localparam int TOTAL_BITS = CMD_BITS + DATA_W;
  localparam int GAP_CYCLES = 2 * CLK_DIV;
  localparam int GAP_W      = $clog2(GAP_CYCLES) + 1;

  state_t            state_reg;
  logic [31:0]       tx_reg;
  logic [DATA_W-1:0] rx_reg;
  logic [DATA_W-1:0] rx_swapped;
  logic [7:0]        bit_cnt_reg;
  logic [GAP_W-1:0]  gap_cnt_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic [DATA_W-1:0] resp_data_reg;
  logic              cs_reg;
  logic              mosi_reg;

  logic bit_en;
  logic bit_rise;
  logic bit_fall;
  logic last_bit;
  logic in_data_phase;

  // The first SHIFT cycle only drops chip select; the bit clock starts one cycle later.
  assign bit_en        = (state_reg == SHIFT) && !cs_reg;
  assign last_bit      = bit_cnt_reg == 8'(TOTAL_BITS - 1);
  assign in_data_phase = bit_cnt_reg >= 8'(CMD_BITS);

  spi_bit_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .en     (bit_en),
    .spi_clk(spi_clk),
    .rise   (bit_rise),
    .fall   (bit_fall)
  );

  // rx shifts left, so the first byte received ends up in the top slot; reverse byte order.
  for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_byte_swap
    assign rx_swapped[8*gi +: 8] = rx_reg[DATA_W-8-8*gi +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      tx_reg         <= '0;
      rx_reg         <= '0;
      bit_cnt_reg    <= '0;
      gap_cnt_reg    <= '0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_data_reg  <= '0;
      cs_reg         <= 1'b1;
      mosi_reg       <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          req_ready_reg <= 1'b1;
          if (req_valid && req_ready_reg) begin
            req_ready_reg <= 1'b0;
            tx_reg        <= {SPI_CMD_READ, req_addr};
            rx_reg        <= '0;
            bit_cnt_reg   <= '0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_reg) begin
            cs_reg   <= 1'b0;
            mosi_reg <= tx_reg[31];
            tx_reg   <= {tx_reg[30:0], 1'b0};
          end else begin
            if (bit_rise && in_data_phase) begin
              rx_reg <= {rx_reg[DATA_W-2:0], spi_miso};
            end
            if (bit_fall) begin
              if (last_bit) begin
                state_reg      <= GAP;
                cs_reg         <= 1'b1;
                mosi_reg       <= 1'b0;
                resp_valid_reg <= 1'b1;
                resp_data_reg  <= rx_swapped;
                gap_cnt_reg    <= '0;
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 8'd1;
                mosi_reg    <= tx_reg[31];
                tx_reg      <= {tx_reg[30:0], 1'b0};
              end
            end
          end
        end
        GAP: begin
          // The consumer may take the response while chip select is still being held high.
          gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
          if (resp_valid_reg && resp_ready) begin
            resp_valid_reg <= 1'b0;
          end
          if (gap_cnt_reg == GAP_W'(GAP_CYCLES - 1)) begin
            if (resp_valid_reg && !resp_ready) begin
              state_reg <= RESP;
            end else begin
              state_reg     <= IDLE;
              req_ready_reg <= 1'b1;
            end
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            state_reg      <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_data  = resp_data_reg;
  assign spi_cs     = cs_reg;
  assign spi_mosi   = mosi_reg;

endmodule
